// File: rtl/hpdmc_datactl.sv
// Data-path sequencer feeding hpdmc_ddrio: loads write bursts, times op_write/op_read windows, returns reads.
// Optional macro HPDMC_DATACTL_STATS_EN adds saturating accepted-burst counters.
module hpdmc_datactl #(
  parameter int BURST_LEN = 4,
  parameter int CAS_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CAS_W-1:0] tim_cas,
  input  logic             cmd_write,
  input  logic             cmd_read,
  output logic             write_safe,
  output logic             read_safe,
  output logic             cmd_err,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [63:0]      wr_dat,
  input  logic [7:0]       wr_mask,
  output logic             rd_valid,
  output logic [63:0]      rd_dat,
  output logic             op_write,
  output logic             op_read,
  output logic             buffer_w_next,
  output logic             buffer_w_nextburst,
  output logic [7:0]       buffer_w_mask,
  output logic [63:0]      buffer_w_dat,
  output logic             buffer_r_next,
  output logic             buffer_r_nextburst,
  input  logic [63:0]      buffer_r_dat
`ifdef HPDMC_DATACTL_STATS_EN
  ,
  output logic [15:0]      stat_wbursts,
  output logic [15:0]      stat_rbursts
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_LOADING = 2'd1,
    S_LOADED  = 2'd2,
    S_WRITING = 2'd3
  } wstate_e;

  wstate_e          state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             rd_act_q, rd_act_d;
  logic [4:0]       rcnt_q, rcnt_d;
  logic [CAS_W-1:0] cas_q, cas_d;
  logic             err_q, err_d;
  logic             op_write_q, op_read_q, rd_valid_q, r_next_q, r_nb_q;
  logic             write_safe_q, read_safe_q;
  logic             wr_push, w_acc, r_acc;
  logic [4:0]       casx_d;

  assign wr_ready           = (state_q == S_EMPTY) || (state_q == S_LOADING);
  assign wr_push            = wr_valid & wr_ready;
  assign buffer_w_next      = wr_push;
  assign buffer_w_nextburst = wr_push & (state_q == S_EMPTY);
  assign buffer_w_dat       = wr_dat;
  assign buffer_w_mask      = wr_mask;
  assign rd_dat             = buffer_r_dat;

  assign w_acc = cmd_write & ~cmd_read & write_safe_q;
  assign r_acc = cmd_read & ~cmd_write & read_safe_q;

  // Next-state for the write loader, the read window counter and the error flag
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_EMPTY: begin
        if (wr_push) begin
          state_d = S_LOADING;
          cnt_d   = 3'd1;
        end else begin
          cnt_d   = 3'd0;
        end
      end
      S_LOADING: begin
        if (wr_push) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'(BURST_LEN - 1)) state_d = S_LOADED;
          else                            state_d = S_LOADING;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_LOADED: begin
        if (w_acc) begin
          state_d = S_WRITING;
          cnt_d   = 3'd0;
        end else begin
          state_d = S_LOADED;
        end
      end
      S_WRITING: begin
        // Hold off reloading for one extra cycle after the window: ddrio consumes with a lag
        if (cnt_q == 3'(BURST_LEN)) begin
          state_d = S_EMPTY;
          cnt_d   = 3'd0;
        end else begin
          cnt_d   = cnt_q + 3'd1;
        end
      end
      default: begin
        state_d = S_EMPTY;
        cnt_d   = 3'd0;
      end
    endcase

    rd_act_d = rd_act_q;
    rcnt_d   = rcnt_q;
    cas_d    = cas_q;
    if (r_acc) begin
      rd_act_d = 1'b1;
      rcnt_d   = 5'd1;
      cas_d    = tim_cas;
    end else if (rd_act_q && (rcnt_q == 5'(cas_q) + 5'd9)) begin
      rd_act_d = 1'b0;
      rcnt_d   = 5'd0;
    end else if (rd_act_q) begin
      rcnt_d   = rcnt_q + 5'd1;
    end else begin
      rcnt_d   = 5'd0;
    end
    casx_d = 5'(cas_d);

    err_d = err_q | (cmd_write & cmd_read) | (cmd_write & ~write_safe_q) | (cmd_read & ~read_safe_q);
  end

  // State and registered window/status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_EMPTY;
      cnt_q        <= 3'd0;
      rd_act_q     <= 1'b0;
      rcnt_q       <= 5'd0;
      cas_q        <= '0;
      err_q        <= 1'b0;
      op_write_q   <= 1'b0;
      op_read_q    <= 1'b0;
      rd_valid_q   <= 1'b0;
      r_next_q     <= 1'b0;
      r_nb_q       <= 1'b0;
      write_safe_q <= 1'b0;
      read_safe_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_act_q     <= rd_act_d;
      rcnt_q       <= rcnt_d;
      cas_q        <= cas_d;
      err_q        <= err_d;
      op_write_q   <= (state_d == S_WRITING) && (cnt_d < 3'(BURST_LEN));
      op_read_q    <= rd_act_d && (rcnt_d >= casx_d) && (rcnt_d <= casx_d + 5'd3);
      r_nb_q       <= rd_act_d && (rcnt_d == casx_d + 5'd5);
      rd_valid_q   <= rd_act_d && (rcnt_d >= casx_d + 5'd6) && (rcnt_d <= casx_d + 5'd9);
      r_next_q     <= rd_act_d && (rcnt_d >= casx_d + 5'd6) && (rcnt_d <= casx_d + 5'd9);
      write_safe_q <= (state_d == S_LOADED) && !rd_act_d;
      read_safe_q  <= !rd_act_d && (state_d != S_WRITING);
    end
  end

  assign op_write           = op_write_q;
  assign op_read            = op_read_q;
  assign rd_valid           = rd_valid_q;
  assign buffer_r_next      = r_next_q;
  assign buffer_r_nextburst = r_nb_q;
  assign write_safe         = write_safe_q;
  assign read_safe          = read_safe_q;
  assign cmd_err            = err_q;

`ifdef HPDMC_DATACTL_STATS_EN
  logic [15:0] stat_w_q, stat_r_q;

  // Saturating counts of accepted bursts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_w_q <= 16'd0;
      stat_r_q <= 16'd0;
    end else begin
      if (w_acc && (stat_w_q != 16'hFFFF)) stat_w_q <= stat_w_q + 16'd1;
      if (r_acc && (stat_r_q != 16'hFFFF)) stat_r_q <= stat_r_q + 16'd1;
    end
  end

  assign stat_wbursts = stat_w_q;
  assign stat_rbursts = stat_r_q;
`endif

endmodule

// File: tb/tb_hpdmc_datactl.sv
// Directed, table-driven bench for hpdmc_datactl with a small ddrio read-FIFO model.
module tb_hpdmc_datactl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  tim_cas = 3'd3;
  logic        cmd_write = 1'b0, cmd_read = 1'b0;
  logic        write_safe, read_safe, cmd_err;
  logic        wr_valid = 1'b0, wr_ready;
  logic [63:0] wr_dat = 64'd0;
  logic [7:0]  wr_mask = 8'd0;
  logic        rd_valid;
  logic [63:0] rd_dat;
  logic        op_write, op_read;
  logic        buffer_w_next, buffer_w_nextburst;
  logic [7:0]  buffer_w_mask;
  logic [63:0] buffer_w_dat;
  logic        buffer_r_next, buffer_r_nextburst;
  logic [63:0] buffer_r_dat;
`ifdef HPDMC_DATACTL_STATS_EN
  logic [15:0] stat_wbursts, stat_rbursts;
`endif

  hpdmc_datactl dut (
    .clk(clk), .rst(rst), .tim_cas(tim_cas),
    .cmd_write(cmd_write), .cmd_read(cmd_read),
    .write_safe(write_safe), .read_safe(read_safe), .cmd_err(cmd_err),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_dat(wr_dat), .wr_mask(wr_mask),
    .rd_valid(rd_valid), .rd_dat(rd_dat),
    .op_write(op_write), .op_read(op_read),
    .buffer_w_next(buffer_w_next), .buffer_w_nextburst(buffer_w_nextburst),
    .buffer_w_mask(buffer_w_mask), .buffer_w_dat(buffer_w_dat),
    .buffer_r_next(buffer_r_next), .buffer_r_nextburst(buffer_r_nextburst),
    .buffer_r_dat(buffer_r_dat)
`ifdef HPDMC_DATACTL_STATS_EN
    , .stat_wbursts(stat_wbursts), .stat_rbursts(stat_rbursts)
`endif
  );

  always #5 clk = ~clk;

  // ddrio read FIFO model: nextburst rewinds, next advances
  logic [63:0] rmem [4];
  logic [1:0]  rptr = 2'd2;
  assign buffer_r_dat = rmem[rptr];
  always @(posedge clk) begin
    if (buffer_r_nextburst) rptr <= 2'd0;
    else if (buffer_r_next) rptr <= rptr + 2'd1;
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic exp_err = 1'b0;

  typedef struct {
    logic        v;
    logic [63:0] d;
    logic [7:0]  m;
    logic        e_rdy;
    logic        e_next;
    logic        e_nb;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; cmd_write = 1'b0; cmd_read = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0; exp_err = 1'b0;
    #1;
    chk("rst_wr_ready", 64'(wr_ready), 64'd1);
    chk("rst_write_safe", 64'(write_safe), 64'd0);
    chk("rst_read_safe", 64'(read_safe), 64'd1);
    chk("rst_cmd_err", 64'(cmd_err), 64'd0);
    chk("rst_op", 64'({op_write, op_read, rd_valid, buffer_r_next, buffer_r_nextburst}), 64'd0);
  endtask

  task automatic load_burst();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      wr_valid = tbl[i].v; wr_dat = tbl[i].d; wr_mask = tbl[i].m;
      #1;
      chk("ld_ready", 64'(wr_ready), 64'(tbl[i].e_rdy));
      chk("ld_next", 64'(buffer_w_next), 64'(tbl[i].e_next));
      chk("ld_nextburst", 64'(buffer_w_nextburst), 64'(tbl[i].e_nb));
      chk("ld_dat", buffer_w_dat, tbl[i].d);
      chk("ld_mask", 64'(buffer_w_mask), 64'(tbl[i].m));
    end
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    chk("ld_write_safe", 64'(write_safe), 64'd1);
  endtask

  // Issues cmd_read in the current cycle (k=0), then checks every cycle of the window
  task automatic do_read(input int c, input bit loaded, input int inj_k, input int inj_kind);
    int j;
    j = 0;
    tim_cas = 3'(c); cmd_read = 1'b1;
    #1;
    chk("rd_read_safe_pre", 64'(read_safe), 64'd1);
    for (int k = 1; k <= c + 10; k++) begin
      @(negedge clk);
      cmd_read = 1'b0; cmd_write = 1'b0;
      if (k == 2) tim_cas = 3'd7;
      if (k == inj_k && inj_kind == 1) cmd_read = 1'b1;
      if (k == inj_k && inj_kind == 2) cmd_write = 1'b1;
      #1;
      chk("rd_op_read", 64'(op_read), 64'(k >= c && k <= c + 3));
      chk("rd_nextburst", 64'(buffer_r_nextburst), 64'(k == c + 5));
      chk("rd_valid", 64'(rd_valid), 64'(k >= c + 6 && k <= c + 9));
      chk("rd_next", 64'(buffer_r_next), 64'(k >= c + 6 && k <= c + 9));
      chk("rd_read_safe", 64'(read_safe), 64'(k >= c + 10));
      chk("rd_write_safe", 64'(write_safe), 64'(loaded && k >= c + 10));
      chk("rd_op_write", 64'(op_write), 64'd0);
      chk("rd_cmd_err", 64'(cmd_err), 64'(exp_err));
      if (k >= c + 6 && k <= c + 9) begin
        chk("rd_dat", rd_dat, rmem[j]);
        j++;
      end
      if (k == inj_k) exp_err = 1'b1;
    end
    cmd_read = 1'b0; cmd_write = 1'b0;
  endtask

  // Issues cmd_write in the current cycle; optional async reset at cycle rst_k
  task automatic do_write(input int rst_k);
    cmd_write = 1'b1;
    #1;
    chk("wr_write_safe_pre", 64'(write_safe), 64'd1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      cmd_write = 1'b0;
      #1;
      if (k == rst_k) begin
        chk("wr_op_write_prerst", 64'(op_write), 64'd1);
        rst = 1'b1;
        #1;
        chk("wr_op_write_rst", 64'(op_write), 64'd0);
        chk("wr_ready_rst", 64'(wr_ready), 64'd1);
        chk("wr_write_safe_rst", 64'(write_safe), 64'd0);
        @(negedge clk);
        rst = 1'b0; exp_err = 1'b0;
        #1;
        chk("wr_op_write_post", 64'(op_write), 64'd0);
        chk("wr_write_safe_post", 64'(write_safe), 64'd0);
        break;
      end
      chk("wr_op_write", 64'(op_write), 64'(k <= 4));
      chk("wr_ready", 64'(wr_ready), 64'(k >= 6));
      chk("wr_read_safe", 64'(read_safe), 64'(k >= 6));
      chk("wr_write_safe", 64'(write_safe), 64'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) rmem[i] = 64'hD0D0_0000_0000_0000 | 64'(i);
    tbl[0] = '{1'b0, 64'h55, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 64'h0,  8'h00, 1'b1, 1'b1, 1'b1};
    tbl[2] = '{1'b0, 64'h77, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 64'h1,  8'h00, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 64'h2,  8'h0F, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 64'h3,  8'h00, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 64'h9,  8'hFF, 1'b0, 1'b0, 1'b0};

    reset_dut();
    load_burst();
    do_write(0);
    do_read(3, 1'b0, 0, 0);
    do_read(2, 1'b0, 5, 1);
    do_read(2, 1'b0, 0, 0);

    // Simultaneous commands with a burst loaded and reads idle
    reset_dut();
    load_burst();
    cmd_write = 1'b1; cmd_read = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      cmd_write = 1'b0; cmd_read = 1'b0;
      #1;
      chk("sim_windows", 64'({op_write, op_read, rd_valid}), 64'd0);
      chk("sim_cmd_err", 64'(cmd_err), 64'd1);
      chk("sim_write_safe", 64'(write_safe), 64'd1);
      chk("sim_read_safe", 64'(read_safe), 64'd1);
    end

    // Turnaround: write blocked during read, burst survives, then write with reset at T+2
    reset_dut();
    load_burst();
    do_read(3, 1'b1, 2, 2);
    do_write(2);

    do_read(2, 1'b0, 0, 0);
    do_read(2, 1'b0, 0, 0);
    do_read(2, 1'b0, 0, 0);
`ifdef HPDMC_DATACTL_STATS_EN
    chk("stat_rbursts", 64'(stat_rbursts), 64'd3);
    chk("stat_wbursts", 64'(stat_wbursts), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
